fb_port_arbiter: RTL and testbench
==================================

Name: fb_port_arbiter

Overview:
- Shares one single-port, 1-bit frame-buffer RAM (512x342) between three users: the Mac SE video-out reader, the HDMI scaler writer, and an internal clear engine.
- The reader has absolute priority, because video timing is hard real-time. The writer gets a valid/ready handshake. The clear engine fills the whole buffer with one value on command.
- Sits between the scaler, the video generator and the RAM primitive.

Parameters:
- BUFFER_WIDTH, 512, pixels per line
- BUFFER_HEIGHT, 342, lines
- ADDR_WIDTH, 18, address width; must satisfy 2^ADDR_WIDTH >= DEPTH, where DEPTH = BUFFER_WIDTH*BUFFER_HEIGHT = 175104
- RAM_LATENCY, 1, cycles from mem_en to valid mem_rdata

Ports:
- clk  in  1  single system clock
- reset_n  in  1  asynchronous, active-low reset
- rd_req  in  1  reader requests a pixel this cycle
- rd_addr  in  ADDR_WIDTH  reader pixel address
- rd_valid  out  1  rd_data valid
- rd_data  out  1  returned pixel
- wr_valid  in  1  scaler has a pixel to write
- wr_addr  in  ADDR_WIDTH  write pixel address
- wr_data  in  1  write pixel value
- wr_ready  out  1  write accepted this cycle when wr_valid=1
- clr_start  in  1  one-cycle clear command
- clr_value  in  1  fill value, sampled with clr_start
- clr_busy  out  1  clear in progress
- clr_done  out  1  one-cycle pulse when clear completes
- addr_err  out  1  sticky out-of-range flag
- mem_en  out  1  RAM access enable
- mem_we  out  1  RAM write enable
- mem_addr  out  ADDR_WIDTH  RAM address
- mem_wdata  out  1  RAM write data
- mem_rdata  in  1  RAM read data

Behaviour:
- Reset (asynchronous, reset_n=0):
  - state=IDLE, clr_ptr=0, read pipe cleared.
  - rd_valid, rd_data, clr_busy, clr_done, addr_err are all 0.
  - wr_ready=0 while reset_n=0.
- States: IDLE and CLEAR.
- Grant priority each cycle: read > clear (state CLEAR) > write (state IDLE). Exactly one grant per cycle, or none.
- mem_* outputs are combinational from the grant. With no grant, mem_en=0, mem_we=0 and mem_addr/mem_wdata hold 0.
- Read:
  - Condition: rd_req=1 and rd_addr<DEPTH.
  - Drives mem_en=1, mem_we=0, mem_addr=rd_addr.
  - Request in cycle N gives rd_valid=1 with rd_data=mem_rdata in cycle N+RAM_LATENCY+1, i.e. fixed latency 2 at default.
  - Back-to-back reads every cycle are supported, one result per cycle in order.
- Write:
  - wr_ready = reset_n & (state==IDLE) & ~rd_req.
  - Transfer occurs when wr_valid & wr_ready: mem_we=1, mem_addr=wr_addr, mem_wdata=wr_data.
  - While not ready, the writer must hold wr_valid/wr_addr/wr_data stable.
- Clear:
  - clr_start in IDLE latches clr_value, sets clr_ptr=0 and moves to CLEAR; clr_busy=1 from the next cycle.
  - In CLEAR, each cycle without rd_req writes the latched value at clr_ptr, then clr_ptr increments.
  - Cycles with rd_req stall the pointer.
  - After writing address DEPTH-1: return to IDLE, clr_busy=0 and clr_done=1 for exactly one cycle.
  - Minimum clear time is DEPTH cycles.
  - clr_start during CLEAR is ignored.
- Simultaneous events:
  - clr_start with an accepted write in IDLE: the write completes that cycle and the clear begins next cycle.
  - clr_start with rd_req: the read is served and the clear still starts.
- Out-of-range address (>= DEPTH):
  - A read returns rd_data=0 with rd_valid=1 at normal latency, with no mem_en.
  - A write is accepted (wr_ready rule unchanged) and discarded, with no mem_en.
  - Either case sets addr_err=1; only reset clears it.
- Reset mid-clear: aborts immediately, no clr_done pulse, buffer contents undefined.
- Counter widths: clr_ptr is ADDR_WIDTH bits. The comparison with DEPTH-1 uses full width and never wraps.

Decomposition:
- Package fb_pkg: BUFFER_WIDTH, BUFFER_HEIGHT, DEPTH, ADDR_WIDTH constants; arbiter state encoding (IDLE, CLEAR); grant encoding (NONE, RD, CLR, WR).
- One sub-module, fb_read_pipe: a RAM_LATENCY+1 deep valid/out-of-range delay line. It registers mem_rdata (or 0 for out-of-range) into rd_data.

Test Plan:
- Reset, then write addr 0..9 with data i[0] and no reads; wr_ready=1 throughout. Then read 0..9 back-to-back: rd_valid from cycle N+2, data 0,1,0,1,... in order.
- rd_req held high with wr_valid=1, addr=5, data=1: wr_ready=0 every cycle and no mem_we. Drop rd_req: write accepted the same cycle, and a later read of 5 returns 1.
- clr_start with clr_value=1 and no reads: clr_busy for exactly 175104 cycles, clr_done pulses once. Reads of 0, 87551 and 175103 all return 1.
- Clear with rd_req asserted on every 4th cycle: the clear takes 175104 plus the stall count cycles, and all reads return valid data at latency 2.
- Read of addr 175104 returns rd_valid=1, rd_data=0, addr_err=1, with no mem_en. addr_err stays set until reset_n=0.
- Assert reset_n=0 at clear pointer 1000: clr_busy=0 immediately and no clr_done pulse. After release, state is IDLE and wr_ready=1.

Source files
------------

// File: rtl/fb_port_arbiter_pkg.sv
// Shared constants and encodings for the frame-buffer port arbiter.
// Geometry defaults describe the Mac SE 512x342 monochrome buffer.
package fb_pkg;

    localparam int BUFFER_WIDTH  = 512;
    localparam int BUFFER_HEIGHT = 342;
    localparam int DEPTH         = BUFFER_WIDTH * BUFFER_HEIGHT;
    localparam int ADDR_WIDTH    = 18;
    localparam int RAM_LATENCY   = 1;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } arb_state_t;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        RD   = 2'd1,
        CLR  = 2'd2,
        WR   = 2'd3
    } grant_t;

endpackage

// File: rtl/fb_port_arbiter_if.sv
// Reader, writer, clear-command and RAM-side signals of the frame-buffer arbiter.
// slave is the arbiter's view; master is the surrounding users/RAM view.
interface fb_port_arbiter_if #(
    parameter int ADDR_WIDTH = fb_pkg::ADDR_WIDTH
);
    logic                  rd_req;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  rd_valid;
    logic                  rd_data;

    logic                  wr_valid;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic                  wr_data;
    logic                  wr_ready;

    logic                  clr_start;
    logic                  clr_value;
    logic                  clr_busy;
    logic                  clr_done;
    logic                  addr_err;

    logic                  mem_en;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_wdata;
    logic                  mem_rdata;

    modport slave (
        input  rd_req, rd_addr, wr_valid, wr_addr, wr_data, clr_start, clr_value, mem_rdata,
        output rd_valid, rd_data, wr_ready, clr_busy, clr_done, addr_err,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output rd_req, rd_addr, wr_valid, wr_addr, wr_data, clr_start, clr_value, mem_rdata,
        input  rd_valid, rd_data, wr_ready, clr_busy, clr_done, addr_err,
               mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/fb_port_arbiter_read_pipe.sv
// Read return pipe: delays each granted read RAM_LATENCY+1 cycles and registers the pixel.
// No backpressure; out-of-range reads return 0 at the same latency.
module fb_read_pipe #(
    parameter int RAM_LATENCY = fb_pkg::RAM_LATENCY
) (
    input  logic clk,
    input  logic reset_n,
    input  logic req,
    input  logic oor,
    input  logic mem_rdata,
    output logic rd_valid,
    output logic rd_data
);

    logic [RAM_LATENCY-1:0] vld_sr;
    logic [RAM_LATENCY-1:0] oor_sr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_sr   <= '0;
            oor_sr   <= '0;
            rd_valid <= 1'b0;
            rd_data  <= 1'b0;
        end else begin
            vld_sr[0] <= req;
            oor_sr[0] <= oor;
            for (int i = 1; i < RAM_LATENCY; i++) begin
                vld_sr[i] <= vld_sr[i-1];
                oor_sr[i] <= oor_sr[i-1];
            end
            rd_valid <= vld_sr[RAM_LATENCY-1];
            // mem_rdata only carries this read's pixel in the last delay stage
            rd_data  <= vld_sr[RAM_LATENCY-1] & ~oor_sr[RAM_LATENCY-1] & mem_rdata;
        end
    end

endmodule

// File: rtl/fb_port_arbiter.sv
// Single-port frame-buffer arbiter: read > clear > write, read data after RAM_LATENCY+1 cycles.
// Reads never stall; writes see wr_ready low while reading or clearing; clear stalls on reads.
module fb_port_arbiter #(
    parameter int BUFFER_WIDTH  = fb_pkg::BUFFER_WIDTH,
    parameter int BUFFER_HEIGHT = fb_pkg::BUFFER_HEIGHT,
    parameter int ADDR_WIDTH    = fb_pkg::ADDR_WIDTH,
    parameter int RAM_LATENCY   = fb_pkg::RAM_LATENCY
) (
    input  logic             clk,
    input  logic             reset_n,
    fb_port_arbiter_if.slave bus
);
    import fb_pkg::*;

    localparam int                    DEPTH     = BUFFER_WIDTH * BUFFER_HEIGHT;
    localparam logic [ADDR_WIDTH:0]   DEPTH_W   = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    arb_state_t            state;
    grant_t                grant;
    logic [ADDR_WIDTH-1:0] clr_ptr;
    logic                  clr_val;
    logic                  rd_in;
    logic                  wr_in;
    logic                  en;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  wdata;
    logic                  busy;
    logic                  done;
    logic                  err;
    logic                  pipe_vld;
    logic                  pipe_dat;

    // Full-width compare so addresses >= DEPTH never alias onto valid pixels
    assign rd_in = ({1'b0, bus.rd_addr} < DEPTH_W);
    assign wr_in = ({1'b0, bus.wr_addr} < DEPTH_W);

    always_comb begin
        grant = NONE;
        if (reset_n) begin
            if (bus.rd_req)
                grant = RD;
            else if (state == CLEAR)
                grant = CLR;
            else if (bus.wr_valid)
                grant = WR;
        end
    end

    always_comb begin
        en    = 1'b0;
        we    = 1'b0;
        addr  = '0;
        wdata = 1'b0;
        case (grant)
            RD: begin
                if (rd_in) begin
                    en   = 1'b1;
                    addr = bus.rd_addr;
                end
            end
            CLR: begin
                en    = 1'b1;
                we    = 1'b1;
                addr  = clr_ptr;
                wdata = clr_val;
            end
            WR: begin
                if (wr_in) begin
                    en    = 1'b1;
                    we    = 1'b1;
                    addr  = bus.wr_addr;
                    wdata = bus.wr_data;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            clr_ptr <= '0;
            clr_val <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            done <= 1'b0;
            if ((grant == RD && !rd_in) || (grant == WR && !wr_in))
                err <= 1'b1;
            case (state)
                IDLE: begin
                    if (bus.clr_start) begin
                        clr_val <= bus.clr_value;
                        clr_ptr <= '0;
                        busy    <= 1'b1;
                        state   <= CLEAR;
                    end
                end
                CLEAR: begin
                    if (grant == CLR) begin
                        if (clr_ptr == LAST_ADDR) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= IDLE;
                        end else begin
                            clr_ptr <= clr_ptr + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    fb_read_pipe #(
        .RAM_LATENCY (RAM_LATENCY)
    ) u_read_pipe (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (grant == RD),
        .oor       (~rd_in),
        .mem_rdata (bus.mem_rdata),
        .rd_valid  (pipe_vld),
        .rd_data   (pipe_dat)
    );

    assign bus.wr_ready  = reset_n & (state == IDLE) & ~bus.rd_req;
    assign bus.mem_en    = en;
    assign bus.mem_we    = we;
    assign bus.mem_addr  = addr;
    assign bus.mem_wdata = wdata;
    assign bus.clr_busy  = busy;
    assign bus.clr_done  = done;
    assign bus.addr_err  = err;
    assign bus.rd_valid  = pipe_vld;
    assign bus.rd_data   = pipe_dat;

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Bench for fb_port_arbiter on a reduced 16x12 buffer so full clears stay short.
// A queue/array reference model predicts every output each cycle.
module tb_fb_port_arbiter;

    localparam int TW = 16;
    localparam int TH = 12;
    localparam int D  = TW * TH;
    localparam int AW = 18;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    fb_port_arbiter_if #(.ADDR_WIDTH(AW)) bus ();

    fb_port_arbiter #(
        .BUFFER_WIDTH  (TW),
        .BUFFER_HEIGHT (TH),
        .ADDR_WIDTH    (AW),
        .RAM_LATENCY   (1)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // External single-port RAM, one cycle read latency
    logic ram [D];
    always @(posedge clk) begin
        if (bus.mem_en && int'(bus.mem_addr) < D) begin
            if (bus.mem_we)
                ram[int'(bus.mem_addr)] <= bus.mem_wdata;
            else
                bus.mem_rdata <= ram[int'(bus.mem_addr)];
        end
    end

    typedef struct {
        int due;
        bit dat;
    } rd_exp_t;

    rd_exp_t pend[$];
    bit      model_mem [D];
    int      cyc, m_ptr, stalls;
    bit      m_clr, m_val, m_done, m_err;
    int      checks, failures;
    logic    obs_busy, obs_done;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive at posedge+1, compare at negedge, then advance the model
    task automatic step(input bit rq, input int ra, input bit wv, input int wa,
                        input bit wd, input bit cs, input bit cv);
        bit      rd_in, wr_in, exp_valid, exp_data, exp_ready, exp_en, exp_we, exp_wd, start;
        int      exp_addr;
        rd_exp_t e;
        bus.rd_req    = rq;
        bus.rd_addr   = AW'(ra);
        bus.wr_valid  = wv;
        bus.wr_addr   = AW'(wa);
        bus.wr_data   = wd;
        bus.clr_start = cs;
        bus.clr_value = cv;
        @(negedge clk);
        rd_in     = ra < D;
        wr_in     = wa < D;
        exp_valid = pend.size() > 0 && pend[0].due == cyc;
        exp_data  = 1'b0;
        if (exp_valid) begin
            e = pend.pop_front();
            exp_data = e.dat;
        end
        exp_ready = !m_clr && !rq;
        exp_en    = rq ? rd_in : (m_clr ? 1'b1 : (wv && wr_in));
        exp_we    = !rq && (m_clr || (wv && wr_in));
        exp_wd    = m_clr ? m_val : wd;
        exp_addr  = !exp_en ? 0 : (rq ? ra : (m_clr ? m_ptr : wa));
        chk("rd_valid", bus.rd_valid, exp_valid);
        if (exp_valid) chk("rd_data", bus.rd_data, exp_data);
        chk("wr_ready", bus.wr_ready, exp_ready);
        chk("clr_busy", bus.clr_busy, m_clr);
        chk("clr_done", bus.clr_done, m_done);
        chk("addr_err", bus.addr_err, m_err);
        chk("mem_en", bus.mem_en, exp_en);
        chk("mem_we", bus.mem_we, exp_we);
        chk("mem_addr", bus.mem_addr, exp_addr);
        if (exp_we) chk("mem_wdata", bus.mem_wdata, exp_wd);
        obs_busy = bus.clr_busy;
        obs_done = bus.clr_done;
        start  = cs && !m_clr;
        m_done = 1'b0;
        if (rq) begin
            e.due = cyc + 2;
            e.dat = rd_in ? model_mem[ra] : 1'b0;
            pend.push_back(e);
            if (!rd_in) m_err = 1'b1;
            if (m_clr) stalls++;
        end else if (m_clr) begin
            model_mem[m_ptr] = m_val;
            if (m_ptr == D - 1) begin
                m_clr  = 1'b0;
                m_done = 1'b1;
            end else begin
                m_ptr++;
            end
        end else if (wv) begin
            if (wr_in) model_mem[wa] = wd;
            else m_err = 1'b1;
        end
        if (start) begin
            m_clr = 1'b1;
            m_ptr = 0;
            m_val = cv;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle();
        step(1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int  busy_cnt, done_cnt, k;
        bit  w_pend, w_data, rq, acc;
        int  w_addr, ra;
        checks = 0; failures = 0; cyc = 0; stalls = 0;
        m_clr = 0; m_val = 0; m_done = 0; m_err = 0; m_ptr = 0;

        // Reset state, with a write offered to prove wr_ready is held low
        reset_n = 1'b0;
        bus.rd_req = 0; bus.rd_addr = '0; bus.wr_valid = 1; bus.wr_addr = '0;
        bus.wr_data = 0; bus.clr_start = 0; bus.clr_value = 0;
        @(negedge clk);
        chk("rst_rd_valid", bus.rd_valid, 0);
        chk("rst_rd_data", bus.rd_data, 0);
        chk("rst_clr_busy", bus.clr_busy, 0);
        chk("rst_clr_done", bus.clr_done, 0);
        chk("rst_addr_err", bus.addr_err, 0);
        chk("rst_wr_ready", bus.wr_ready, 0);
        chk("rst_mem_en", bus.mem_en, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Writes 0..9 then back-to-back reads
        for (int i = 0; i < 10; i++) step(1'b0, 0, 1'b1, i, i[0], 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b1, i, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        idle(); idle();

        // Read holds off a pending write, which lands once rd_req drops
        repeat (5) step(1'b1, 3, 1'b1, 5, 1'b1, 1'b0, 1'b0);
        step(1'b0, 0, 1'b1, 5, 1'b1, 1'b0, 1'b0);
        step(1'b1, 5, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        idle(); idle();

        // Clear to 1 started alongside an accepted write; a second start mid-clear is ignored
        step(1'b0, 0, 1'b1, 9, 1'b0, 1'b1, 1'b1);
        busy_cnt = 0; done_cnt = 0;
        for (k = 0; k < D + 20; k++) begin
            step(1'b0, 0, 1'b0, 0, 1'b0, k == 50, 1'b0);
            busy_cnt += int'(obs_busy);
            done_cnt += int'(obs_done);
            if (obs_done) break;
        end
        chk("clr1_busy_cycles", busy_cnt, D);
        chk("clr1_done_pulses", done_cnt, 1);
        step(1'b1, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        step(1'b1, D / 2 - 1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        step(1'b1, D - 1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        idle(); idle();

        // Clear to 0 started with a read; reads stall it every 4th cycle
        step(1'b1, 7, 1'b0, 0, 1'b0, 1'b1, 1'b0);
        busy_cnt = 0; done_cnt = 0; stalls = 0;
        for (k = 0; k < 2 * D + 20; k++) begin
            step(k % 4 == 3, int'($urandom_range(D - 1)), 1'b0, 0, 1'b0, 1'b0, 1'b0);
            busy_cnt += int'(obs_busy);
            done_cnt += int'(obs_done);
            if (obs_done) break;
        end
        chk("clr2_busy_cycles", busy_cnt, D + stalls);
        chk("clr2_done_pulses", done_cnt, 1);
        idle(); idle();

        // Random traffic; the writer holds its request until accepted
        w_pend = 0; w_addr = 0; w_data = 0;
        for (int n = 0; n < 1500; n++) begin
            if (!w_pend && $urandom_range(1) == 1) begin
                w_pend = 1;
                w_addr = int'($urandom_range(D - 1));
                w_data = $urandom_range(1) == 1;
            end
            rq  = $urandom_range(2) == 0;
            ra  = int'($urandom_range(D - 1));
            acc = w_pend && !m_clr && !rq;
            step(rq, ra, w_pend, w_addr, w_data, $urandom_range(399) == 0, $urandom_range(1) == 1);
            if (acc) w_pend = 0;
        end
        for (k = 0; k < 2 * D && (m_clr || m_done); k++) idle();
        idle(); idle();

        // Out-of-range read and writes: data 0 at normal latency, sticky addr_err
        step(1'b1, D, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        idle(); idle();
        step(1'b0, 0, 1'b1, D + 5, 1'b1, 1'b0, 1'b0);
        step(1'b0, 0, 1'b1, (1 << AW) - 1, 1'b1, 1'b0, 1'b0);
        repeat (4) idle();

        // Reset in the middle of a clear
        step(1'b0, 0, 1'b0, 0, 1'b0, 1'b1, 1'b1);
        for (k = 0; k < 4 * D && m_ptr < 100; k++) idle();
        chk("abort_ptr_reached", m_ptr, 100);
        bus.rd_req = 0; bus.wr_valid = 0; bus.clr_start = 0;
        reset_n = 1'b0;
        #1;
        chk("abort_clr_busy", bus.clr_busy, 0);
        chk("abort_clr_done", bus.clr_done, 0);
        chk("abort_addr_err", bus.addr_err, 0);
        chk("abort_wr_ready", bus.wr_ready, 0);
        repeat (3) begin
            @(negedge clk);
            chk("abort_no_done", bus.clr_done, 0);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        m_clr = 0; m_done = 0; m_err = 0; m_ptr = 0;
        pend.delete();
        step(1'b0, 0, 1'b1, 3, 1'b1, 1'b0, 1'b0);
        idle(); idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
